// File: rtl/rom_reader_pkg.sv
// rom_reader_pkg
//   Shared constants and types for the ROM stream reader.
//   - ROM_ADDR_W / ROM_DATA_W : default geometry of the 64x4 ROM
//   - S_IDLE / S_RUN / S_FIN  : FSM encodings, also used as the enum values
//   - buf_entry_t             : one output buffer slot {data, last}
package rom_reader_pkg;

   localparam int ROM_ADDR_W = 6;
   localparam int ROM_DATA_W = 4;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIN  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = S_IDLE,
      ST_RUN  = S_RUN,
      ST_FIN  = S_FIN
   } state_e;

   typedef struct packed {
      logic [ROM_DATA_W-1:0] data;
      logic                  last;
   } buf_entry_t;

endpackage

// File: rtl/rom_skid_buf.sv
// rom_skid_buf
//   Two-entry FIFO that decouples the ROM read timing from downstream
//   backpressure. A push and a pop in the same cycle are both honoured.
//   flush empties the buffer and takes priority over push and pop.
// Ports
//   clk, rst_n            clock, async active-low reset
//   push, push_data/last  write one entry (dropped if full and not popping)
//   pop                   remove the head entry (ignored when empty)
//   flush                 discard all entries
//   count                 registered occupancy, 0..2
//   head_data/head_last   head entry contents
module rom_skid_buf
   import rom_reader_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [ROM_DATA_W-1:0] push_data,
   input  logic                  push_last,
   input  logic                  pop,
   input  logic                  flush,
   output logic [1:0]            count,
   output logic [ROM_DATA_W-1:0] head_data,
   output logic                  head_last
);

   buf_entry_t mem_q [2];
   buf_entry_t mem_d [2];
   logic       wr_ptr_q, wr_ptr_d;
   logic       rd_ptr_q, rd_ptr_d;
   logic [1:0] count_q, count_d;
   logic       do_push, do_pop;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      do_pop   = pop && (count_q != 2'd0);
      do_push  = push && ((count_q != 2'd2) || do_pop);
      if (flush) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = '{data: push_data, last: push_last};
            wr_ptr_d        = ~wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign count     = count_q;
   assign head_data = mem_q[rd_ptr_q].data;
   assign head_last = mem_q[rd_ptr_q].last;

endmodule

// File: rtl/rom_stream_reader.sv
// rom_stream_reader
//   Reads a block of consecutive words from a 64x4 asynchronous ROM and
//   streams them out on a valid/ready interface with a last flag and a
//   done pulse. Reads are gated only by registered state, so m_ready never
//   reaches rom_en/rom_addr combinationally.
// Ports
//   clk, rst_n              clock, async active-low reset
//   start, base_addr, len   block request, sampled in IDLE only
//   abort                   terminate an active transfer (RUN only)
//   rom_en, rom_addr        ROM read strobe and address
//   rom_dout                ROM data, same-cycle with rom_en/rom_addr
//   m_valid/m_ready         output handshake
//   m_data, m_last          output word and final-word flag
//   busy, done              RUN indicator, one-cycle completion pulse
//   checksum                XOR of accepted words (ROM_READER_CHECKSUM_EN only)
// Build option
//   ROM_READER_CHECKSUM_EN  adds the checksum output and its register.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing reads and draining the output buffer
// FIN   | done pulse, returns to IDLE
module rom_stream_reader
   import rom_reader_pkg::*;
#(
   parameter int ADDR_W = ROM_ADDR_W,
   parameter int DATA_W = ROM_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   len,
   input  logic              abort,
   output logic              rom_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_dout,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   output logic              busy,
   output logic              done
`ifdef ROM_READER_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0] checksum
`endif
);

   localparam logic [ADDR_W:0]   REM_ONE  = 1;
   localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic [ADDR_W:0]   rem_q, rem_d;
   logic              rd_en, pop, flush, start_acc;
   logic [1:0]        buf_count;
   logic [DATA_W-1:0] head_data;
   logic              head_last;

   assign start_acc = (state_q == ST_IDLE) && start;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rem_d      = rem_q;
      rom_addr_d = rom_addr_q;
      rd_en      = 1'b0;
      pop        = 1'b0;
      flush      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_acc) begin
               addr_d  = base_addr;
               rem_d   = len;
               state_d = (len == '0) ? ST_FIN : ST_RUN;
            end
         end
         ST_RUN: begin
            if (abort) begin
               flush   = 1'b1;
               rem_d   = '0;
               state_d = ST_FIN;
            end else begin
               rd_en = (rem_q != '0) && (buf_count != 2'd2);
               pop   = m_valid && m_ready;
               if (rd_en) begin
                  addr_d     = addr_q + ADDR_ONE;
                  rem_d      = rem_q - REM_ONE;
                  rom_addr_d = addr_q;
               end
               // Leave as soon as the last buffered word is handed off, so
               // done lands in the cycle right after the m_last handshake.
               if ((rem_q == '0) &&
                   ((buf_count == 2'd0) || ((buf_count == 2'd1) && pop))) begin
                  state_d = ST_FIN;
               end
            end
         end
         ST_FIN: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         rom_addr_q <= '0;
         rem_q      <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rom_addr_q <= rom_addr_d;
         rem_q      <= rem_d;
      end
   end

   rom_skid_buf u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (rd_en),
      .push_data (rom_dout),
      .push_last (rem_q == REM_ONE),
      .pop       (pop),
      .flush     (flush),
      .count     (buf_count),
      .head_data (head_data),
      .head_last (head_last)
   );

   // rom_addr shows the live address only during a read and otherwise
   // holds the address of the most recent read.
   assign rom_en   = rd_en;
   assign rom_addr = rd_en ? addr_q : rom_addr_q;
   assign m_valid  = (buf_count != 2'd0);
   assign m_data   = head_data;
   assign m_last   = head_last;
   assign busy     = (state_q == ST_RUN);
   assign done     = (state_q == ST_FIN);

`ifdef ROM_READER_CHECKSUM_EN
   logic [DATA_W-1:0] csum_q, csum_d;

   always_comb begin
      csum_d = csum_q;
      if (start_acc) begin
         csum_d = '0;
      end else if (pop) begin
         csum_d = csum_q ^ m_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csum_q <= '0;
      end else begin
         csum_q <= csum_d;
      end
   end

   assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_rom_stream_reader.sv
// tb_rom_stream_reader
//   Scoreboard bench: stimulus pushes expected words into exp_q, a negedge
//   monitor pops and compares on every accepted word.
module tb_rom_stream_reader;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [5:0] base_addr = '0;
   logic [6:0] len = '0;
   logic       abort = 1'b0;
   logic       rom_en;
   logic [5:0] rom_addr;
   logic [3:0] rom_dout;
   logic       m_valid;
   logic       m_ready = 1'b0;
   logic [3:0] m_data;
   logic       m_last;
   logic       busy;
   logic       done;
`ifdef ROM_READER_CHECKSUM_EN
   logic [3:0] checksum;
`endif

   rom_stream_reader dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .len       (len),
      .abort     (abort),
      .rom_en    (rom_en),
      .rom_addr  (rom_addr),
      .rom_dout  (rom_dout),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_last    (m_last),
      .busy      (busy),
      .done      (done)
`ifdef ROM_READER_CHECKSUM_EN
      ,
      .checksum  (checksum)
`endif
   );

   always #5 clk = ~clk;

   logic [3:0] rom_mem [64];
   assign rom_dout = rom_mem[rom_addr];

   typedef struct {
      logic [3:0] data;
      logic       last;
   } exp_t;

   exp_t exp_q [$];
   int   addr_log [$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   int   done_cyc = -1;
   int   first_valid_cyc = -1;
   int   rom_en_cnt = 0;
   int   valid_cnt = 0;

   always @(posedge clk) cyc++;

   // Monitor: spec cycle index of the current negedge is cyc+1.
   always @(negedge clk) begin
      if (rst_n) begin
         if (m_valid && m_ready && !abort) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL word_unexpected got data=%0d last=%0d want none", m_data, m_last);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (m_data !== e.data || m_last !== e.last) begin
                  errors++;
                  $display("FAIL word got data=%0d last=%0d want data=%0d last=%0d",
                           m_data, m_last, e.data, e.last);
               end
            end
         end
         if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc + 1;
         if (m_valid) valid_cnt++;
         if (rom_en) begin
            addr_log.push_back(int'(rom_addr));
            rom_en_cnt++;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc + 1;
         end
      end
   end

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d", nm, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic exp_word(input logic [3:0] d, input logic l);
      exp_t e;
      e.data = d;
      e.last = l;
      exp_q.push_back(e);
   endtask

   task automatic clear_logs();
      addr_log.delete();
      rom_en_cnt      = 0;
      valid_cnt       = 0;
      first_valid_cyc = -1;
      done_cyc        = -1;
   endtask

   task automatic do_start(input int b, input int l, output int k);
      base_addr = 6'(b);
      len       = 7'(l);
      start     = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      k     = cyc;
   endtask

   task automatic wait_done(input int n0, input string nm);
      int t = 0;
      while (done_cnt == n0 && t < 80) begin
         tick(1);
         t++;
      end
      chk(nm, done_cnt - n0, 1);
   endtask

   task automatic chk_addrs(input string nm, input int a0, input int n);
      chk({nm, "_nreads"}, addr_log.size(), n);
      for (int i = 0; i < n && i < addr_log.size(); i++)
         chk({nm, "_addr"}, addr_log[i], (a0 + i) % 64);
   endtask

   initial begin
      int k, n0;
      for (int i = 0; i < 64; i++) rom_mem[i] = 4'((i * 5 + 7) & 15);
      rom_mem[0]  = 4'd4;
      rom_mem[1]  = 4'd2;
      rom_mem[2]  = 4'd0;
      rom_mem[3]  = 4'd3;
      rom_mem[62] = 4'd4;
      rom_mem[63] = 4'd15;

      // reset state
      tick(2);
      chk("rst_rom_en", rom_en, 0);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      rst_n = 1'b1;
      tick(2);
      chk("idle_m_valid", m_valid, 0);
      chk("idle_m_data", m_data, 0);
      chk("idle_m_last", m_last, 0);

      // base 0, len 4, m_ready high
      clear_logs();
      m_ready = 1'b1;
      exp_word(4'd4, 1'b0);
      exp_word(4'd2, 1'b0);
      exp_word(4'd0, 1'b0);
      exp_word(4'd3, 1'b1);
      n0 = done_cnt;
      do_start(0, 4, k);
      chk("t1_busy", busy, 1);
      chk("t1_first_rom_en", rom_en, 1);
      chk("t1_first_addr", rom_addr, 0);
      wait_done(n0, "t1_done_seen");
      chk("t1_done_cyc", done_cyc, k + 6);
      chk("t1_first_valid_cyc", first_valid_cyc, k + 2);
      chk_addrs("t1", 0, 4);
      tick(2);
      chk("t1_q_empty", exp_q.size(), 0);
      chk("t1_addr_hold", rom_addr, 3);
`ifdef ROM_READER_CHECKSUM_EN
      chk("t1_checksum", checksum, 5);
`endif

      // address wrap 62..1
      clear_logs();
      exp_word(4'd4, 1'b0);
      exp_word(4'd15, 1'b0);
      exp_word(4'd4, 1'b0);
      exp_word(4'd2, 1'b1);
      n0 = done_cnt;
      do_start(62, 4, k);
      wait_done(n0, "t2_done_seen");
      chk_addrs("t2", 62, 4);
      tick(2);
      chk("t2_q_empty", exp_q.size(), 0);

      // len 0
      clear_logs();
      n0 = done_cnt;
      do_start(7, 0, k);
      wait_done(n0, "t3_done_seen");
      chk("t3_done_cyc", done_cyc, k + 1);
      tick(2);
      chk("t3_rom_en_cnt", rom_en_cnt, 0);
      chk("t3_valid_cnt", valid_cnt, 0);

      // backpressure: len 8, m_ready low 5 cycles
      clear_logs();
      m_ready = 1'b0;
      for (int i = 0; i < 8; i++) exp_word(rom_mem[10 + i], i == 7);
      n0 = done_cnt;
      do_start(10, 8, k);
      tick(5);
      chk("t4_stall_reads", rom_en_cnt, 2);
      chk("t4_stall_valid", m_valid, 1);
      m_ready = 1'b1;
      wait_done(n0, "t4_done_seen");
      chk_addrs("t4", 10, 8);
      tick(2);
      chk("t4_q_empty", exp_q.size(), 0);

      // abort in 3rd RUN cycle of len 10
      clear_logs();
      exp_word(rom_mem[20], 1'b0);
      n0 = done_cnt;
      do_start(20, 10, k);
      tick(2);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      chk("t5_valid_after_abort", m_valid, 0);
      chk("t5_done_after_abort", done, 1);
      chk("t5_busy_after_abort", busy, 0);
      chk("t5_reads", rom_en_cnt, 2);
      tick(3);
      chk("t5_done_once", done_cnt - n0, 1);
      chk("t5_idle", busy, 0);
      chk("t5_q_empty", exp_q.size(), 0);
`ifdef ROM_READER_CHECKSUM_EN
      chk("t5_checksum", checksum, rom_mem[20]);
`endif

      // start while busy is ignored
      clear_logs();
      for (int i = 0; i < 4; i++) exp_word(rom_mem[5 + i], i == 3);
      n0 = done_cnt;
      do_start(5, 4, k);
      start     = 1'b1;
      base_addr = 6'd40;
      len       = 7'd3;
      tick(1);
      start = 1'b0;
      wait_done(n0, "t6_done_seen");
      tick(4);
      chk("t6_done_once", done_cnt - n0, 1);
      chk("t6_busy", busy, 0);
      chk_addrs("t6", 5, 4);
      chk("t6_q_empty", exp_q.size(), 0);

      // reset mid-transfer
      clear_logs();
      for (int i = 0; i < 8; i++) exp_word(rom_mem[i], i == 7);
      do_start(0, 8, k);
      tick(3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t7_rst_rom_en", rom_en, 0);
      chk("t7_rst_rom_addr", rom_addr, 0);
      chk("t7_rst_m_valid", m_valid, 0);
      chk("t7_rst_m_data", m_data, 0);
      chk("t7_rst_m_last", m_last, 0);
      chk("t7_rst_busy", busy, 0);
      chk("t7_rst_done", done, 0);
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick(1);
      clear_logs();
      exp_word(4'd4, 1'b0);
      exp_word(4'd15, 1'b1);
      n0 = done_cnt;
      do_start(62, 2, k);
      wait_done(n0, "t7_done_seen");
      chk("t7_done_cyc", done_cyc, k + 4);
      chk_addrs("t7", 62, 2);
      tick(2);
      chk("t7_q_empty", exp_q.size(), 0);
`ifdef ROM_READER_CHECKSUM_EN
      chk("t7_checksum", checksum, 11);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      errors++;
      $display("FAIL global_timeout got=running want=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/rom_stream_reader.md
# rom_stream_reader

Address sequencer and output buffer for the 64x4 asynchronous ROM. On a start command it drives `rom_en` and `rom_addr` over a block of consecutive addresses and captures the combinational `rom_dout` each cycle. It then streams the words downstream on a valid/ready interface, with a last-word flag and a done pulse. It sits between the control logic and the ROM's consumers, and it keeps `m_ready` off the ROM address path.

## Interface
- `ADDR_W`, 6, ROM address width; the address space is 2^ADDR_W words.
- `DATA_W`, 4, ROM data width.
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  start command, sampled only in IDLE.
- `base_addr`  in  ADDR_W  first address, sampled with `start`.
- `len`  in  ADDR_W+1  word count, 0..2^ADDR_W, sampled with `start`.
- `abort`  in  1  terminates an active transfer.
- `rom_en`  out  1  ROM read enable.
- `rom_addr`  out  ADDR_W  ROM address.
- `rom_dout`  in  DATA_W  ROM data, valid in the same cycle as `rom_en`/`rom_addr`.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  DATA_W  output word.
- `m_last`  out  1  marks the final word of the block.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- FSM states:
  - IDLE: `start` moves to RUN, or to FIN if `len`=0. The block loads `addr`←`base_addr` and `remaining`←`len`.
  - RUN: issues reads. When `remaining`=0 and the buffer is empty, it moves to FIN.
  - FIN: `done`=1 for one cycle, then IDLE.
- Read issue in RUN:
  - `rom_en`=1 exactly when `remaining`≠0 and the registered buffer count is <2.
  - The ROM word is pushed into the buffer at the same edge, and the buffer does not look at `m_ready` when deciding to push.
  - The pushed entry carries `last` = (`remaining`==1).
  - After the read, `addr`←`addr`+1 modulo 2^ADDR_W, so the address wraps from 63 to 0, and `remaining` decrements.
- Output buffer:
  - 2-entry FIFO. `m_valid` = count≠0, and `m_data`/`m_last` come from the head entry.
  - The head pops on `m_valid & m_ready`.
  - A push and a pop in the same cycle are both honoured, so steady state runs at one word per cycle.
- `rom_addr` holds its last value while `rom_en`=0.
- `start` outside IDLE is ignored.
- `abort`:
  - Ignored in IDLE and FIN.
  - In RUN it flushes the buffer, zeroes `remaining`, suppresses that cycle's read, and moves to FIN.
  - `abort` wins over a simultaneous pop or push.
- `busy` = 1 in RUN, 0 in IDLE and FIN.
- Reset mid-transfer returns to IDLE immediately and clears all state.
- Reset values: `rom_en`=0, `rom_addr`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `busy`=0, `done`=0; internal counters 0; buffer empty.

## Timing
- Start latency:
  - `start` is sampled at edge k, and RUN begins in cycle k+1.
  - The first `rom_en` is in cycle k+1, with `rom_addr`=`base_addr`.
  - The first `m_valid` is in cycle k+2.
- Throughput is 1 word/cycle while `m_ready` is held high.
- Backpressure:
  - The buffer fills to 2, after which `rom_en` drops.
  - Reads resume in the cycle after the count falls below 2.
- The address and data path are purely registered-count gated, so there is no combinational path from `m_ready` to `rom_en`/`rom_addr`.
- Completion:
  - `done` pulses in the cycle after the handshake of the `m_last` word.
  - For `len`=0, `done` pulses in cycle k+1, with no `rom_en` and no `m_valid`.
  - For `abort` at edge j, `done` pulses in cycle j+1, and `m_valid`=0 from cycle j+1.

## Configuration
- `ROM_READER_CHECKSUM_EN` defined:
  - Adds output `checksum`, width DATA_W.
  - It is the XOR of all words accepted on the `m` interface in the current transfer.
  - Cleared when `start` is accepted; stable and valid while `done`=1 and afterwards.
  - It is not cleared by `abort`, so it covers the words accepted before the abort.
- Undefined: the `checksum` port and its logic are absent. All other behaviour is identical.

## Structure
- `rom_reader_pkg`:
  - FSM state enum (IDLE, RUN, FIN).
  - Default ADDR_W/DATA_W constants.
  - Buffer entry struct {data, last}.
- Sub-module `rom_skid_buf`: the 2-entry FIFO with push, pop, flush, count, head data and head last.
- The FSM, address counter and remaining counter live in the top module.

## Test plan
- With `base_addr`=0, `len`=4 and `m_ready`=1:
  - `m_data` is 4,2,0,3 on consecutive cycles from k+2.
  - `m_last` is high only on the 3.
  - `done` pulses at k+6.
  - With the macro defined, `checksum`=5.
- With `base_addr`=62, `len`=4: `rom_addr` sequence is 62,63,0,1, and `m_data` is 4,15,4,2.
- With `len`=0: `done` pulses in cycle k+1, and `rom_en` and `m_valid` never assert.
- With `len`=8, `m_ready`=0 for 5 cycles, then 1:
  - `rom_en` asserts for exactly 2 cycles, then stays low until `m_ready` rises.
  - All 8 words arrive in order, with none lost or duplicated.
- With `abort` in the 3rd RUN cycle of a `len`=10 transfer: the buffer is flushed, `m_valid`=0 next cycle, `done` pulses once, and the block returns to IDLE.
- `start` pulsed while `busy`: ignored.
- `rst_n` low mid-transfer: all outputs 0 asynchronously, and the next `start` behaves as from a fresh reset.
